// File: rtl/alu_stage.sv
// Execute stage: req/ack capture from decode, single-cycle ALU ops plus an optional
// iterative shift-add multiply (enabled by defining ALU_MUL_EN), req/ack writeback.
module alu_stage #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_req,
    output logic              in_ack,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic              wb_req,
    input  logic              wb_ack,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [WIDTH-1:0]  wb_result,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v,
    output logic              illegal_op,
    output logic              busy
);

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL_ITER = 2'd2, WB_WAIT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB_WAIT = 2'd3} state_t;
`endif

    state_t             state_r, state_s;
    logic [3:0]         opcode_r, opcode_s;
    logic [ADDR_W-1:0]  rd_r, rd_s, wb_rd_s;
    logic [WIDTH-1:0]   a_r, a_s, b_r, b_s, wb_result_s, res_s;
    logic [WIDTH:0]     sum_s, diff_s;
    logic [3:0]         sh_s;
    logic               in_ack_s, wb_req_s, illegal_s, z_s, n_s, c_s, v_s;
    logic               legal_s, is_cmp_s, upd_cv_s, cout_s, ovf_s;
`ifdef ALU_MUL_EN
    logic               is_mul_s;
    logic [WIDTH-1:0]   acc_r, acc_s, acc_add_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
`endif

    assign sh_s   = b_r[3:0];
    assign sum_s  = {1'b0, a_r} + {1'b0, b_r};
    // The extra top bit of the widened difference is the unsigned borrow.
    assign diff_s = {1'b0, a_r} - {1'b0, b_r};
    assign busy   = (state_r != IDLE);

    // Operation decode and result/flag candidates for the latched operands.
    always_comb begin
        res_s    = '0;
        legal_s  = 1'b1;
        is_cmp_s = 1'b0;
        upd_cv_s = 1'b0;
        cout_s   = 1'b0;
        ovf_s    = 1'b0;
`ifdef ALU_MUL_EN
        is_mul_s = 1'b0;
`endif
        case (opcode_r)
            4'h0: begin
                res_s    = sum_s[WIDTH-1:0];
                upd_cv_s = 1'b1;
                cout_s   = sum_s[WIDTH];
                ovf_s    = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
            end
            4'h1, 4'hA: begin
                res_s    = diff_s[WIDTH-1:0];
                upd_cv_s = 1'b1;
                cout_s   = diff_s[WIDTH];
                ovf_s    = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
                is_cmp_s = (opcode_r == 4'hA);
            end
            4'h2: res_s = a_r & b_r;
            4'h3: res_s = a_r | b_r;
            4'h4: res_s = a_r ^ b_r;
            4'h5: res_s = ~a_r;
            4'h6: res_s = a_r << sh_s;
            4'h7: res_s = a_r >> sh_s;
            4'h8: res_s = $signed(a_r) >>> sh_s;
`ifdef ALU_MUL_EN
            4'h9: is_mul_s = 1'b1;
`endif
            4'hB: res_s = b_r;
            default: legal_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_s     = state_r;
        in_ack_s    = 1'b0;
        illegal_s   = 1'b0;
        wb_req_s    = wb_req;
        wb_rd_s     = wb_rd;
        wb_result_s = wb_result;
        z_s         = flag_z;
        n_s         = flag_n;
        c_s         = flag_c;
        v_s         = flag_v;
        opcode_s    = opcode_r;
        rd_s        = rd_r;
        a_s         = a_r;
        b_s         = b_r;
`ifdef ALU_MUL_EN
        acc_s       = acc_r;
        cnt_s       = cnt_r;
        acc_add_s   = acc_r + (b_r[0] ? a_r : {WIDTH{1'b0}});
`endif
        case (state_r)
            IDLE: begin
                if (in_req) begin
                    opcode_s = opcode;
                    rd_s     = rd;
                    a_s      = op_a;
                    b_s      = op_b;
                    in_ack_s = 1'b1;
                    state_s  = EXEC;
                end else begin
                    state_s  = IDLE;
                end
            end
            EXEC: begin
                if (!legal_s) begin
                    illegal_s = 1'b1;
                    state_s   = IDLE;
`ifdef ALU_MUL_EN
                end else if (is_mul_s) begin
                    acc_s   = '0;
                    cnt_s   = '0;
                    state_s = MUL_ITER;
`endif
                end else begin
                    z_s = (res_s == {WIDTH{1'b0}});
                    n_s = res_s[WIDTH-1];
                    if (upd_cv_s) begin
                        c_s = cout_s;
                        v_s = ovf_s;
                    end else begin
                        c_s = flag_c;
                        v_s = flag_v;
                    end
                    if (is_cmp_s) begin
                        state_s = IDLE;
                    end else begin
                        wb_req_s    = 1'b1;
                        wb_rd_s     = rd_r;
                        wb_result_s = res_s;
                        state_s     = WB_WAIT;
                    end
                end
            end
`ifdef ALU_MUL_EN
            MUL_ITER: begin
                // Multiplicand shifts left, multiplier shifts right; one bit per cycle.
                acc_s = acc_add_s;
                a_s   = a_r << 1;
                b_s   = b_r >> 1;
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    wb_req_s    = 1'b1;
                    wb_rd_s     = rd_r;
                    wb_result_s = acc_add_s;
                    z_s         = (acc_add_s == {WIDTH{1'b0}});
                    n_s         = acc_add_s[WIDTH-1];
                    state_s     = WB_WAIT;
                end else begin
                    state_s     = MUL_ITER;
                end
            end
`endif
            WB_WAIT: begin
                if (wb_ack) begin
                    wb_req_s = 1'b0;
                    state_s  = IDLE;
                end else begin
                    state_s  = WB_WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand and output registers; reset drops any in-flight op at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            opcode_r   <= 4'h0;
            rd_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            in_ack     <= 1'b0;
            wb_req     <= 1'b0;
            wb_rd      <= '0;
            wb_result  <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            illegal_op <= 1'b0;
`ifdef ALU_MUL_EN
            acc_r      <= '0;
            cnt_r      <= '0;
`endif
        end else begin
            state_r    <= state_s;
            opcode_r   <= opcode_s;
            rd_r       <= rd_s;
            a_r        <= a_s;
            b_r        <= b_s;
            in_ack     <= in_ack_s;
            wb_req     <= wb_req_s;
            wb_rd      <= wb_rd_s;
            wb_result  <= wb_result_s;
            flag_z     <= z_s;
            flag_n     <= n_s;
            flag_c     <= c_s;
            flag_v     <= v_s;
            illegal_op <= illegal_s;
`ifdef ALU_MUL_EN
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed scenarios plus randomized ops against
// an arithmetic reference model. MUL expectations follow ALU_MUL_EN.
module tb_alu_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_req, in_ack, wb_req, wb_ack, illegal_op, busy;
    logic [3:0]  opcode, rd, wb_rd;
    logic [15:0] op_a, op_b, wb_result;
    logic        flag_z, flag_n, flag_c, flag_v;

    int checks = 0;
    int passed = 0;
    bit m_z, m_n, m_c, m_v;

    always #5 clk = ~clk;

    alu_stage #(.WIDTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack), .opcode(opcode),
        .rd(rd), .op_a(op_a), .op_b(op_b), .wb_req(wb_req), .wb_ack(wb_ack),
        .wb_rd(wb_rd), .wb_result(wb_result), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .illegal_op(illegal_op), .busy(busy)
    );

    function automatic logic [27:0] all_outs();
        return {in_ack, wb_req, wb_rd, wb_result, flag_z, flag_n, flag_c, flag_v, illegal_op, busy};
    endfunction

    function automatic logic [3:0] flags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    // Reference: plain integer arithmetic; updates model flags, returns result.
    task automatic model_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] res, output bit legal, output bit wb);
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint p = 1;
        longint t = 0;
        repeat (b[3:0]) p = p * 2;
        legal = 1; wb = 1; res = 16'h0;
        case (op)
            4'h0: begin t = ua + ub; res = t[15:0]; m_c = (t > 65535);
                        m_v = ((sa + sb) > 32767) || ((sa + sb) < -32768); end
            4'h1, 4'hA: begin t = ua - ub; res = t[15:0]; m_c = (ua < ub);
                        m_v = ((sa - sb) > 32767) || ((sa - sb) < -32768); wb = (op == 4'h1); end
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = ~a;
            4'h6: begin t = ua * p; res = t[15:0]; end
            4'h7: begin t = ua / p; res = t[15:0]; end
            4'h8: begin t = (sa >= 0) ? (sa / p) : -(((-sa) + p - 1) / p); res = t[15:0]; end
            4'h9: begin
`ifdef ALU_MUL_EN
                t = ua * ub; res = t[15:0];
`else
                legal = 0; wb = 0;
`endif
            end
            4'hB: res = b;
            default: begin legal = 0; wb = 0; end
        endcase
        if (legal) begin m_z = (res == 16'h0); m_n = res[15]; end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] r, input logic [15:0] a,
                         input logic [15:0] b, output bit acked);
        opcode = op; rd = r; op_a = a; op_b = b; in_req = 1'b1; acked = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (in_ack) begin acked = 1; break; end
        end
        in_req = 1'b0;
    endtask

    task automatic wait_wb(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (wb_req) begin cyc = i; break; end
        end
    endtask

    task automatic ack_wb();
        wb_ack = 1'b1; @(posedge clk); #1; wb_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_req = 1'b0; wb_ack = 1'b0; opcode = 4'h0; rd = 4'h0; op_a = 16'h0; op_b = 16'h0;
        #2;
        checks++; if (all_outs() !== 28'h0) $display("FAIL reset_outs got %h exp %h", all_outs(), 28'h0); else passed++;
        repeat (2) @(posedge clk); #1; rst = 1'b0;
        m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    endtask

    task automatic test_add_hold();
        bit acked, lg, wb; int cyc; logic [15:0] e; bit stable = 1;
        model_op(4'h0, 16'h7FFF, 16'h0001, e, lg, wb);
        issue(4'h0, 4'd3, 16'h7FFF, 16'h0001, acked);
        checks++; if (!acked) $display("FAIL add_ack got %0d exp 1", acked); else passed++;
        wait_wb(10, cyc);
        checks++; if (cyc !== 1) $display("FAIL add_latency got %0d exp 1", cyc); else passed++;
        checks++; if ({wb_rd, wb_result} !== {4'd3, 16'h8000}) $display("FAIL add_data got %h exp %h", {wb_rd, wb_result}, {4'd3, 16'h8000}); else passed++;
        checks++; if (flags() !== 4'b0101) $display("FAIL add_flags got %b exp %b", flags(), 4'b0101); else passed++;
        repeat (5) begin
            @(posedge clk); #1;
            if (!(wb_req === 1'b1 && wb_rd === 4'd3 && wb_result === e)) stable = 0;
        end
        checks++; if (!stable) $display("FAIL wb_hold got %h exp %h", {wb_req, wb_rd, wb_result}, {1'b1, 4'd3, e}); else passed++;
        ack_wb();
        checks++; if ({wb_req, busy} !== 2'b00) $display("FAIL add_release got %b exp 00", {wb_req, busy}); else passed++;
    endtask

    task automatic test_sub_cmp();
        bit acked, lg, wb, seen = 0; int cyc; logic [15:0] e;
        model_op(4'h1, 16'h0003, 16'h0005, e, lg, wb);
        issue(4'h1, 4'd1, 16'h0003, 16'h0005, acked);
        wait_wb(10, cyc);
        checks++; if (wb_result !== 16'hFFFE) $display("FAIL sub_result got %h exp %h", wb_result, 16'hFFFE); else passed++;
        checks++; if (flags() !== 4'b0110) $display("FAIL sub_flags got %b exp %b", flags(), 4'b0110); else passed++;
        ack_wb();
        model_op(4'hA, 16'h0005, 16'h0005, e, lg, wb);
        issue(4'hA, 4'd2, 16'h0005, 16'h0005, acked);
        repeat (6) begin @(posedge clk); #1; if (wb_req) seen = 1; end
        checks++; if (seen) $display("FAIL cmp_no_wb got 1 exp 0"); else passed++;
        checks++; if (flags() !== 4'b1000) $display("FAIL cmp_flags got %b exp %b", flags(), 4'b1000); else passed++;
    endtask

    task automatic test_mul();
        bit acked, lg, wb; int cyc; logic [15:0] e;
        model_op(4'h9, 16'h0123, 16'h0045, e, lg, wb);
        issue(4'h9, 4'd7, 16'h0123, 16'h0045, acked);
`ifdef ALU_MUL_EN
        wait_wb(30, cyc);
        checks++; if (cyc !== 17) $display("FAIL mul_latency got %0d exp 17", cyc); else passed++;
        checks++; if ({wb_rd, wb_result} !== {4'd7, 16'h4E6F}) $display("FAIL mul_data got %h exp %h", {wb_rd, wb_result}, {4'd7, 16'h4E6F}); else passed++;
        ack_wb();
`else
        @(posedge clk); #1;
        checks++; if ({illegal_op, wb_req, flags()} !== {2'b10, m_z, m_n, m_c, m_v}) $display("FAIL mul_disabled got %b exp %b", {illegal_op, wb_req, flags()}, {2'b10, m_z, m_n, m_c, m_v}); else passed++;
        wait_wb(5, cyc);
        checks++; if (cyc !== -1) $display("FAIL mul_disabled_no_wb got %0d exp -1", cyc); else passed++;
`endif
    endtask

    task automatic test_shifts_illegal();
        logic [3:0]  ops [3] = '{4'h8, 4'h7, 4'h6};
        logic [15:0] as  [3] = '{16'h8000, 16'h8000, 16'h0001};
        logic [15:0] bs  [3] = '{16'h0004, 16'h0004, 16'h000F};
        logic [15:0] exs [3] = '{16'hF800, 16'h0800, 16'h8000};
        bit acked, lg, wb; int cyc; logic [15:0] e;
        for (int i = 0; i < 3; i++) begin
            model_op(ops[i], as[i], bs[i], e, lg, wb);
            issue(ops[i], 4'd9, as[i], bs[i], acked);
            wait_wb(10, cyc);
            checks++; if (wb_result !== exs[i]) $display("FAIL shift_op%0h got %h exp %h", ops[i], wb_result, exs[i]); else passed++;
            ack_wb();
        end
        issue(4'hE, 4'd1, 16'h1234, 16'h5678, acked);
        @(posedge clk); #1;
        checks++; if ({illegal_op, wb_req, flags()} !== {2'b10, m_z, m_n, m_c, m_v}) $display("FAIL illegal_pulse got %b exp %b", {illegal_op, wb_req, flags()}, {2'b10, m_z, m_n, m_c, m_v}); else passed++;
        @(posedge clk); #1;
        checks++; if ({illegal_op, wb_req} !== 2'b00) $display("FAIL illegal_one_cycle got %b exp 00", {illegal_op, wb_req}); else passed++;
    endtask

    task automatic test_random();
        bit acked, lg, wb; int cyc; logic [15:0] e, a, b; logic [3:0] op, r;
        for (int n = 0; n < 24; n++) begin
            op = 4'($urandom_range(0, 15)); r = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
            model_op(op, a, b, e, lg, wb);
            issue(op, r, a, b, acked);
            if (wb) begin
                wait_wb(30, cyc);
                checks++; if ({cyc, wb_rd, wb_result, flags()} !== {((op == 4'h9) ? 17 : 1), r, e, m_z, m_n, m_c, m_v})
                    $display("FAIL rand_op%0h got cyc=%0d %h/%h/%b exp %h/%h/%b", op, cyc, wb_rd, wb_result, flags(), r, e, {m_z, m_n, m_c, m_v});
                else passed++;
                ack_wb();
            end else begin
                @(posedge clk); #1;
                checks++; if ({illegal_op, wb_req, flags()} !== {~lg, 1'b0, m_z, m_n, m_c, m_v})
                    $display("FAIL rand_nowb_op%0h got %b exp %b", op, {illegal_op, wb_req, flags()}, {~lg, 1'b0, m_z, m_n, m_c, m_v});
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] got [$]; logic [15:0] e1, e2; bit lg, wb; int acks = 0; int wbcnt = 0;
        model_op(4'h0, 16'h1234, 16'h1111, e1, lg, wb);
        model_op(4'h4, 16'hF0F0, 16'h0FF0, e2, lg, wb);
        opcode = 4'h0; rd = 4'd2; op_a = 16'h1234; op_b = 16'h1111; in_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            wb_ack = 1'b0;
            if (in_ack) begin
                acks++;
                if (acks == 1) begin opcode = 4'h4; rd = 4'd5; op_a = 16'hF0F0; op_b = 16'h0FF0; end
                else in_req = 1'b0;
            end
            if (wb_req) begin
                wbcnt++;
                if (wbcnt == 2) begin wb_ack = 1'b1; got.push_back({wb_rd, wb_result}); wbcnt = 0; end
            end else wbcnt = 0;
        end
        in_req = 1'b0; wb_ack = 1'b0;
        checks++; if (acks !== 2) $display("FAIL b2b_acks got %0d exp 2", acks); else passed++;
        checks++; if (got.size() !== 2) $display("FAIL b2b_wbs got %0d exp 2", got.size()); else passed++;
        if (got.size() == 2) begin
            checks++; if (got[0] !== {4'd2, e1}) $display("FAIL b2b_first got %h exp %h", got[0], {4'd2, e1}); else passed++;
            checks++; if (got[1] !== {4'd5, e2}) $display("FAIL b2b_second got %h exp %h", got[1], {4'd5, e2}); else passed++;
        end
        checks++; if (flags() !== {m_z, m_n, m_c, m_v}) $display("FAIL b2b_flags got %b exp %b", flags(), {m_z, m_n, m_c, m_v}); else passed++;
    endtask

    task automatic test_reset_mid();
        bit acked, lg, wb; int cyc; logic [15:0] e;
`ifdef ALU_MUL_EN
        issue(4'h9, 4'd8, 16'hABCD, 16'h1357, acked);
        repeat (5) @(posedge clk); #2;
        rst = 1'b1; #1;
        checks++; if (all_outs() !== 28'h0) $display("FAIL rst_in_mul got %h exp %h", all_outs(), 28'h0); else passed++;
        @(posedge clk); #1; rst = 1'b0;
        m_z = 0; m_n = 0; m_c = 0; m_v = 0;
`endif
        issue(4'hB, 4'd4, 16'h0000, 16'h1234, acked);
        wait_wb(10, cyc);
        #2; rst = 1'b1; #1;
        checks++; if (all_outs() !== 28'h0) $display("FAIL rst_in_wb got %h exp %h", all_outs(), 28'h0); else passed++;
        @(posedge clk); #1; rst = 1'b0;
        m_z = 0; m_n = 0; m_c = 0; m_v = 0;
        model_op(4'h0, 16'h0002, 16'h0003, e, lg, wb);
        issue(4'h0, 4'd6, 16'h0002, 16'h0003, acked);
        wait_wb(10, cyc);
        checks++; if ({cyc, wb_rd, wb_result, flags()} !== {1, 4'd6, 16'h0005, 4'b0000})
            $display("FAIL post_reset_add got cyc=%0d %h/%h/%b exp 1/6/0005/0000", cyc, wb_rd, wb_result, flags());
        else passed++;
        ack_wb();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_hold();
        test_sub_cmp();
        test_mul();
        test_shifts_illegal();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
